// File: rtl/pc_sequencer_if.sv
// Control-to-sequencer bundle: redirect requests in, PC/EPC/RAS status out.
// Outputs are all registered inside the sequencer; the only hold mechanism is stall.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic              jump_link;
  logic [ADDR_W-1:0] jump_target;
  logic              jump_reg;
  logic [ADDR_W-1:0] jr_target;
  logic              ret;
  logic              trap;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] epc;
  logic              misaligned;
  logic              ras_empty;
  logic              ras_overflow;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_link, jump_target,
           jump_reg, jr_target, ret, trap,
    input  pc, epc, misaligned, ras_empty, ras_overflow
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_link, jump_target,
           jump_reg, jr_target, ret, trap,
    output pc, epc, misaligned, ras_empty, ras_overflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered PC with prioritised redirect, return-address stack and trap capture.
// Redirects land on pc one edge later; under stall they park in a pending register.
module pc_sequencer #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [31:0]       TRAP_VEC    = 32'h0000_0080,
  parameter int                INSTR_BYTES = 4,
  parameter int                RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.slave   bus
);
  localparam int                PTR_W      = $clog2(RAS_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] TRAP_PC    = ADDR_W'(TRAP_VEC);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_epc;
  logic              r_misaligned;
  logic              r_pend_vld;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  logic [ADDR_W-1:0] w_seq;
  logic [PTR_W-1:0]  w_top_inc;
  logic              w_redir;
  logic [ADDR_W-1:0] w_tgt;
  logic              w_push;
  logic              w_pop;
  logic              w_commit_vld;
  logic [ADDR_W-1:0] w_commit_tgt;
  logic              w_commit_bad;

  assign w_seq     = r_pc + STEP;
  assign w_top_inc = r_top + PTR_W'(1);

  // Trap wins outright and performs no RAS operation, so it is excluded here.
  always_comb begin
    w_redir = 1'b0;
    w_tgt   = bus.branch_target;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    if (!bus.trap) begin
      if (bus.ret) begin
        w_redir = 1'b1;
        if (r_cnt == '0) begin
          w_tgt = bus.jr_target;
        end else begin
          w_tgt = r_ras[r_top];
          w_pop = 1'b1;
        end
      end else if (bus.jump_reg) begin
        w_redir = 1'b1;
        w_tgt   = bus.jr_target;
      end else if (bus.jump) begin
        w_redir = 1'b1;
        w_tgt   = bus.jump_target;
        w_push  = bus.jump_link;
      end else if (bus.branch_taken) begin
        w_redir = 1'b1;
        w_tgt   = bus.branch_target;
      end
    end
  end

  // A fresh redirect beats whatever was parked during the stall.
  assign w_commit_vld = w_redir || r_pend_vld;
  assign w_commit_tgt = w_redir ? w_tgt : r_pend_tgt;
  assign w_commit_bad = w_commit_vld && ((w_commit_tgt & ALIGN_MASK) != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_epc        <= '0;
      r_misaligned <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_pend_tgt   <= '0;
      r_top        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      if (bus.trap) begin
        r_epc      <= r_pc;
        r_pc       <= TRAP_PC;
        r_pend_vld <= 1'b0;
      end else if (bus.stall) begin
        if (w_redir) begin
          r_pend_vld <= 1'b1;
          r_pend_tgt <= w_redir ? w_tgt : r_pend_tgt;
        end
      end else begin
        r_pend_vld <= 1'b0;
        if (!w_commit_vld) begin
          r_pc <= w_seq;
        end else if (w_commit_bad) begin
          r_pc         <= TRAP_PC;
          r_epc        <= w_commit_tgt;
          r_misaligned <= 1'b1;
        end else begin
          r_pc <= w_commit_tgt;
        end
      end

      // Circular stack: a push on a full stack lands on the oldest slot.
      if (w_push) begin
        r_top          <= w_top_inc;
        r_ras[w_top_inc] <= w_seq;
        if (r_cnt == CNT_FULL) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_pop) begin
        r_top <= r_top - PTR_W'(1);
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.pc           = r_pc;
  assign bus.epc          = r_epc;
  assign bus.misaligned   = r_misaligned;
  assign bus.ras_empty    = (r_cnt == '0);
  assign bus.ras_overflow = r_ovf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed scenarios then random redirect traffic.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] TRAPV  = 32'h80;
  localparam int          DEPTH  = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic        emp;
    logic        ovf;
    logic        den;
    logic [31:0] dpc;
    logic        deen;
    logic [31:0] depc;
  } exp_t;

  logic clk;
  logic rst_n;
  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W(32), .RESET_PC(RST_PC), .TRAP_VEC(TRAPV), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [31:0] ras_q[$];
  logic [31:0] m_pc, m_epc, m_pt;
  logic        m_mis, m_pv, m_ovf;
  logic        d_en, de_en;
  logic [31:0] d_pc, d_epc;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RAS as a bounded queue (oldest at front), pending as a plain slot.
  task automatic model_step();
    logic [31:0] tgt;
    logic        redir;
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (!rst_n) begin
      m_pc = RST_PC; m_epc = 0; m_mis = 0; m_pv = 0; m_ovf = 0;
      ras_q.delete();
    end else begin
      redir = 0; tgt = 0; m_mis = 0;
      if (!bus.trap) begin
        if (bus.ret) begin
          redir = 1;
          tgt = (ras_q.size() == 0) ? bus.jr_target : ras_q.pop_back();
        end else if (bus.jump_reg) begin
          redir = 1; tgt = bus.jr_target;
        end else if (bus.jump) begin
          redir = 1; tgt = bus.jump_target;
          if (bus.jump_link) begin
            ras_q.push_back(seq);
            if (ras_q.size() > DEPTH) begin
              void'(ras_q.pop_front());
              m_ovf = 1;
            end
          end
        end else if (bus.branch_taken) begin
          redir = 1; tgt = bus.branch_target;
        end
      end
      if (bus.trap) begin
        m_epc = m_pc; m_pc = TRAPV; m_pv = 0;
      end else if (bus.stall) begin
        if (redir) begin m_pv = 1; m_pt = tgt; end
      end else begin
        if (!redir && m_pv) begin redir = 1; tgt = m_pt; end
        m_pv = 0;
        if (!redir) m_pc = seq;
        else if (tgt[1:0] != 2'b00) begin m_epc = tgt; m_pc = TRAPV; m_mis = 1; end
        else m_pc = tgt;
      end
    end
  endtask

  task automatic clear_in();
    rst_n = 1'b1;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_link = 0; bus.jump_target = 0;
    bus.jump_reg = 0; bus.jr_target = 0; bus.ret = 0; bus.trap = 0;
  endtask

  // Inputs are set at a falling edge; one expectation per rising edge.
  task automatic cyc();
    exp_t e;
    model_step();
    e.pc = m_pc; e.epc = m_epc; e.mis = m_mis; e.emp = (ras_q.size() == 0); e.ovf = m_ovf;
    e.den = d_en; e.dpc = d_pc; e.deen = de_en; e.depc = d_epc;
    exp_q.push_back(e);
    d_en = 0; de_en = 0;
    @(negedge clk);
    clear_in();
  endtask

  task automatic want_pc(input logic [31:0] v);
    d_en = 1; d_pc = v;
  endtask

  task automatic want_epc(input logic [31:0] v);
    de_en = 1; d_epc = v;
  endtask

  task automatic do_jump(input logic [31:0] t, input logic link, input logic [31:0] dpc);
    bus.jump = 1; bus.jump_target = t; bus.jump_link = link;
    want_pc(dpc);
    cyc();
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", bus.pc, e.pc);
        check("epc", bus.epc, e.epc);
        check("misaligned", {31'd0, bus.misaligned}, {31'd0, e.mis});
        check("ras_empty", {31'd0, bus.ras_empty}, {31'd0, e.emp});
        check("ras_overflow", {31'd0, bus.ras_overflow}, {31'd0, e.ovf});
        if (e.den) check("plan_pc", bus.pc, e.dpc);
        if (e.deen) check("plan_epc", bus.epc, e.depc);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    d_en = 0; de_en = 0; d_pc = 0; d_epc = 0;
    m_pc = 0; m_epc = 0; m_pt = 0; m_mis = 0; m_pv = 0; m_ovf = 0;
    clear_in();

    // Reset then sequential
    rst_n = 0; want_pc(0); want_epc(0); cyc();
    rst_n = 0; want_pc(0); cyc();
    want_pc(32'h4); cyc();
    want_pc(32'h8); cyc();
    want_pc(32'hC); cyc();

    // Priority: jump_reg beats jump and branch; trap beats ret
    do_jump(32'h10, 0, 32'h10);
    bus.branch_taken = 1; bus.branch_target = 32'h40;
    bus.jump = 1; bus.jump_target = 32'h80;
    bus.jump_reg = 1; bus.jr_target = 32'hC0;
    want_pc(32'hC0); cyc();
    bus.trap = 1; bus.ret = 1; bus.jr_target = 32'h300;
    want_pc(TRAPV); want_epc(32'hC0); cyc();

    // Stall with pending redirect, newest wins
    do_jump(32'h20, 0, 32'h20);
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h100; want_pc(32'h20); cyc();
    bus.stall = 1; bus.jump = 1; bus.jump_target = 32'h200; want_pc(32'h20); cyc();
    bus.stall = 1; want_pc(32'h20); cyc();
    want_pc(32'h200); cyc();
    want_pc(32'h204); cyc();

    // RAS calls with overflow, then returns down to empty
    do_jump(32'h0, 0, 32'h0);
    for (int i = 1; i <= 5; i++) do_jump(32'(i) << 8, 1, 32'(i) << 8);
    for (int i = 4; i >= 1; i--) begin
      bus.ret = 1; bus.jr_target = 32'hDEAD0;
      want_pc((32'(i) << 8) + 32'h4); cyc();
    end
    bus.ret = 1; bus.jr_target = 32'hDEAD0; want_pc(32'hDEAD0); cyc();

    // Misaligned jump
    do_jump(32'h102, 0, TRAPV);
    want_epc(32'h102); want_pc(TRAPV + 32'h4); cyc();

    // Wrap, then reset while a redirect is pending
    do_jump(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    want_pc(32'h0); cyc();
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h300; want_pc(32'h0); cyc();
    rst_n = 0; bus.stall = 1; want_pc(RST_PC); cyc();
    want_pc(RST_PC + 32'h4); cyc();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n             = ($urandom_range(0, 99) != 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.trap          = ($urandom_range(0, 19) == 0);
      bus.ret           = ($urandom_range(0, 5) == 0);
      bus.jump_reg      = ($urandom_range(0, 7) == 0);
      bus.jump          = ($urandom_range(0, 3) == 0);
      bus.jump_link     = ($urandom_range(0, 1) == 0);
      bus.branch_taken  = ($urandom_range(0, 3) == 0);
      bus.branch_target = rnd_tgt();
      bus.jump_target   = rnd_tgt();
      bus.jr_target     = rnd_tgt();
      cyc();
    end

    @(posedge clk);
    #3;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
